// File: rtl/fp_mult_pkg.sv
// Shared types and FP32 helpers for the shared-multiplier arbiter and its siblings.
package fp_mult_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MANT_W  = 23;
    localparam int unsigned FP_W    = 1 + EXP_W + MANT_W;
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned BUS_W   = MAX_REQ * FP_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Extract operand idx from a packed requester bus (zero-extended to BUS_W).
    function automatic logic [FP_W-1:0] fp_slice(input logic [BUS_W-1:0] bus,
                                                 input int unsigned      idx);
        return bus[idx*FP_W +: FP_W];
    endfunction

endpackage

// File: rtl/fp_mult_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt_c,
    output logic [PTR_W-1:0] o_idx_c,
    output logic             o_any_c
);

    int unsigned w_pos;

    always_comb begin
        o_gnt_c = '0;
        o_idx_c = '0;
        o_any_c = 1'b0;
        w_pos   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_pos = 32'(i_ptr) + k;
            if (w_pos >= N_REQ) begin
                w_pos = w_pos - N_REQ;
            end
            if (!o_any_c && i_req[PTR_W'(w_pos)]) begin
                o_any_c                 = 1'b1;
                o_idx_c                 = PTR_W'(w_pos);
                o_gnt_c[PTR_W'(w_pos)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Round-robin sequencer sharing one fixed-latency FP32 multiplier among N_REQ requesters.
module fp_mult_arbiter
    import fp_mult_pkg::*;
#(
    parameter  int unsigned N_REQ   = 4,
    parameter  int unsigned MUL_LAT = 1,
    localparam int unsigned PTR_W   = $clog2(N_REQ),
    localparam int unsigned CNT_W   = $clog2(MUL_LAT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*FP_W-1:0] req_dataa,
    input  logic [N_REQ*FP_W-1:0] req_datab,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]       rsp_result,
    output logic                  busy,
    output logic                  mul_en,
    output logic [FP_W-1:0]       mul_dataa,
    output logic [FP_W-1:0]       mul_datab,
    input  logic [FP_W-1:0]       mul_result
);

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_rsp_valid;
    logic [FP_W-1:0]    r_rsp_result;
    logic               r_busy;
    logic               r_mul_en;
    logic [FP_W-1:0]    r_mul_dataa;
    logic [FP_W-1:0]    r_mul_datab;

    logic [N_REQ-1:0]   w_pick_gnt;
    logic [PTR_W-1:0]   w_pick_idx;
    logic               w_pick_any;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_gnt_c (w_pick_gnt),
        .o_idx_c (w_pick_idx),
        .o_any_c (w_pick_any)
    );

    // Sequencer: one grant per IDLE pass, operands held until the product is captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_owner      <= '0;
            r_cnt        <= '0;
            r_gnt        <= '0;
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
            r_busy       <= 1'b0;
            r_mul_en     <= 1'b0;
            r_mul_dataa  <= '0;
            r_mul_datab  <= '0;
        end else begin
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_mul_en    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_owner     <= w_pick_idx;
                        r_mul_dataa <= fp_slice(BUS_W'(req_dataa), 32'(w_pick_idx));
                        r_mul_datab <= fp_slice(BUS_W'(req_datab), 32'(w_pick_idx));
                        r_gnt       <= w_pick_gnt;
                        r_mul_en    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= CNT_W'(MUL_LAT);
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Count of 1 marks the edge where the multiplier output is valid.
                    if (r_cnt == CNT_W'(1)) begin
                        r_rsp_result <= mul_result;
                        r_rsp_valid  <= N_REQ'(1) << r_owner;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_ptr   <= (r_owner == PTR_W'(N_REQ - 1)) ? '0 : r_owner + PTR_W'(1);
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign busy       = r_busy;
    assign mul_en     = r_mul_en;
    assign mul_dataa  = r_mul_dataa;
    assign mul_datab  = r_mul_datab;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Directed bench for fp_mult_arbiter: one instance at MUL_LAT=1, one at MUL_LAT=3.
module tb_fp_mult_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Instance with MUL_LAT = 1
    logic [3:0]   req1;
    logic [127:0] da1, db1;
    logic [3:0]   gnt1, rv1;
    logic [31:0]  res1, ma1, mb1, mr1;
    logic         busy1, men1;

    // Instance with MUL_LAT = 3
    logic [3:0]   req3;
    logic [127:0] da3, db3;
    logic [3:0]   gnt3, rv3;
    logic [31:0]  res3, ma3, mb3, mr3;
    logic         busy3, men3;
    logic [31:0]  p3_0, p3_1, p3_2;

    fp_mult_arbiter #(.N_REQ(4), .MUL_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .req_dataa(da1), .req_datab(db1),
        .gnt(gnt1), .rsp_valid(rv1), .rsp_result(res1), .busy(busy1),
        .mul_en(men1), .mul_dataa(ma1), .mul_datab(mb1), .mul_result(mr1)
    );

    fp_mult_arbiter #(.N_REQ(4), .MUL_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .req(req3), .req_dataa(da3), .req_datab(db3),
        .gnt(gnt3), .rsp_valid(rv3), .rsp_result(res3), .busy(busy3),
        .mul_en(men3), .mul_dataa(ma3), .mul_datab(mb3), .mul_result(mr3)
    );

    // Lookup "multiplier" for the operand pairs used below.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40000000, 32'h40400000}: return 32'h40C00000;
            {32'h3FC00000, 32'h3FC00000}: return 32'h40100000;
            {32'hC0000000, 32'h40400000}: return 32'hC0C00000;
            {32'h00000000, 32'h40400000}: return 32'h00000000;
            {32'h40800000, 32'h3F000000}: return 32'h40000000;
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    // Fixed-latency models; off-cycle values are poisoned to expose a mistimed capture.
    always @(posedge clk) begin
        mr1  <= men1 ? fmul(ma1, mb1) : 32'hBAD0BAD0;
        p3_0 <= men3 ? fmul(ma3, mb3) : 32'hBAD0BAD0;
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign mr3 = p3_2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ops1(input int idx, input logic [31:0] a, input logic [31:0] b);
        da1[idx*32 +: 32] = a;
        db1[idx*32 +: 32] = b;
    endtask

    logic [31:0] exp_res [4];

    initial begin
        reset = 1'b1;
        req1 = '0; da1 = '0; db1 = '0;
        req3 = '0; da3 = '0; db3 = '0;
        tick();
        tick();

        // Reset state
        chk("rst_gnt",    32'(gnt1), 32'h0);
        chk("rst_rv",     32'(rv1),  32'h0);
        chk("rst_res",    res1,      32'h0);
        chk("rst_busy",   32'(busy1), 32'h0);
        chk("rst_men",    32'(men1), 32'h0);
        chk("rst_ma",     ma1,       32'h0);
        chk("rst_mb",     mb1,       32'h0);

        // Single request, 2.0 x 3.0
        reset = 1'b0;
        req1  = 4'b0001;
        ops1(0, 32'h40000000, 32'h40400000);
        tick();
        chk("s_gnt",  32'(gnt1),  32'h1);
        chk("s_men",  32'(men1),  32'h1);
        chk("s_busy", 32'(busy1), 32'h1);
        chk("s_ma",   ma1, 32'h40000000);
        chk("s_mb",   mb1, 32'h40400000);
        req1 = 4'b0000;
        tick();
        chk("s_gnt_c2", 32'(gnt1), 32'h0);
        chk("s_men_c2", 32'(men1), 32'h0);
        chk("s_rv_c2",  32'(rv1),  32'h0);
        tick();
        chk("s_rv",  32'(rv1), 32'h1);
        chk("s_res", res1, 32'h40C00000);
        tick();
        chk("s_rv_c4",   32'(rv1),   32'h0);
        chk("s_busy_c4", 32'(busy1), 32'h0);

        // Simultaneous requests from ptr=0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req1 = 4'b1111;
        ops1(0, 32'h40000000, 32'h40400000); exp_res[0] = 32'h40C00000;
        ops1(1, 32'h3FC00000, 32'h3FC00000); exp_res[1] = 32'h40100000;
        ops1(2, 32'hC0000000, 32'h40400000); exp_res[2] = 32'hC0C00000;
        ops1(3, 32'h00000000, 32'h40400000); exp_res[3] = 32'h00000000;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("m_gnt",  32'(gnt1), 32'(1) << k);
            chk("m_busy_issue", 32'(busy1), 32'h1);
            req1[k] = 1'b0;
            tick();
            chk("m_busy_wait", 32'(busy1), 32'h1);
            tick();
            chk("m_rv",  32'(rv1), 32'(1) << k);
            chk("m_res", res1, exp_res[k]);
            chk("m_busy_resp", 32'(busy1), 32'h1);
            tick();
        end

        // Fairness: 2 re-requests right after its grant while 3 waits
        req1 = 4'b1100;
        ops1(2, 32'h40000000, 32'h40400000);
        ops1(3, 32'hC0000000, 32'h40400000);
        tick();
        chk("f_gnt2a", 32'(gnt1), 32'h4);
        chk("f_ma2a",  ma1, 32'h40000000);
        ops1(2, 32'h3FC00000, 32'h3FC00000);
        tick();
        tick();
        chk("f_rv2a",  32'(rv1), 32'h4);
        chk("f_res2a", res1, 32'h40C00000);
        tick();
        tick();
        chk("f_gnt3",  32'(gnt1), 32'h8);
        chk("f_ma3",   ma1, 32'hC0000000);
        req1[3] = 1'b0;
        tick();
        tick();
        chk("f_rv3",   32'(rv1), 32'h8);
        chk("f_res3",  res1, 32'hC0C00000);
        tick();
        tick();
        chk("f_gnt2b", 32'(gnt1), 32'h4);
        chk("f_ma2b",  ma1, 32'h3FC00000);
        req1[2] = 1'b0;
        tick();
        tick();
        chk("f_rv2b",  32'(rv1), 32'h4);
        chk("f_res2b", res1, 32'h40100000);
        tick();

        // Zero product, wrap from ptr=3 to requester 1
        req1 = 4'b0010;
        ops1(1, 32'h00000000, 32'h40400000);
        tick();
        chk("z_gnt", 32'(gnt1), 32'h2);
        req1 = 4'b0000;
        tick();
        tick();
        chk("z_rv",  32'(rv1), 32'h2);
        chk("z_res", res1, 32'h00000000);
        tick();

        // Reset while WAIT; ptr was 2, must restart from 0
        req1 = 4'b0001;
        ops1(0, 32'h40000000, 32'h40400000);
        tick();
        chk("r_gnt0", 32'(gnt1), 32'h1);
        req1 = 4'b1010;
        ops1(1, 32'h3FC00000, 32'h3FC00000);
        ops1(3, 32'hC0000000, 32'h40400000);
        tick();
        reset = 1'b1;
        tick();
        chk("r_rv",   32'(rv1),   32'h0);
        chk("r_gnt",  32'(gnt1),  32'h0);
        chk("r_busy", 32'(busy1), 32'h0);
        chk("r_men",  32'(men1),  32'h0);
        chk("r_ma",   ma1, 32'h0);
        chk("r_mb",   mb1, 32'h0);
        reset = 1'b0;
        tick();
        chk("r_next_gnt", 32'(gnt1), 32'h2);
        req1 = 4'b1000;
        tick();
        tick();
        chk("r_next_rv",  32'(rv1), 32'h2);
        chk("r_next_res", res1, 32'h40100000);
        req1 = 4'b0000;
        tick();

        // Withdrawn request is never granted
        req1 = 4'b0001;
        ops1(0, 32'h40000000, 32'h40400000);
        tick();
        chk("w_gnt0", 32'(gnt1), 32'h1);
        req1 = 4'b0010;
        tick();
        req1 = 4'b0000;
        tick();
        chk("w_rv0", 32'(rv1), 32'h1);
        tick();
        tick();
        chk("w_no_gnt",  32'(gnt1),  32'h0);
        chk("w_no_busy", 32'(busy1), 32'h0);
        tick();
        chk("w_no_gnt2", 32'(gnt1), 32'h0);

        // MUL_LAT=3 latency and operand hold
        req3 = 4'b0001;
        da3[31:0] = 32'h40800000;
        db3[31:0] = 32'h3F000000;
        tick();
        chk("l_gnt", 32'(gnt3), 32'h1);
        chk("l_men", 32'(men3), 32'h1);
        chk("l_ma1", ma3, 32'h40800000);
        chk("l_mb1", mb3, 32'h3F000000);
        req3 = 4'b0000;
        da3[31:0] = 32'hFFFFFFFF;
        db3[31:0] = 32'hFFFFFFFF;
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk("l_ma_hold", ma3, 32'h40800000);
            chk("l_mb_hold", mb3, 32'h3F000000);
            chk("l_rv_wait", 32'(rv3), 32'h0);
            chk("l_busy",    32'(busy3), 32'h1);
        end
        tick();
        chk("l_rv",  32'(rv3), 32'h1);
        chk("l_res", res3, 32'h40000000);
        tick();
        chk("l_idle", 32'(busy3), 32'h0);
        chk("l_res_hold", res3, 32'h40000000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
